// File: rtl/gnn_pkg.sv
// Shared widths, FSM encoding and flat-vector indexing for the sequential GNN engine.
package gnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AGG1,
    S_MUL1,
    S_AGG2,
    S_MUL2,
    S_OUT
  } state_t;

  function automatic int a1w(int n, int dw);
    return dw + $clog2(n);
  endfunction

  function automatic int hw(int n, int dw, int fin);
    return a1w(n, dw) + dw + $clog2(fin);
  endfunction

  function automatic int a2w(int n, int dw, int fin);
    return hw(n, dw, fin) + $clog2(n);
  endfunction

  function automatic int ow(int n, int dw, int fin, int fhid);
    return a2w(n, dw, fin) + dw + $clog2(fhid);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int flat_idx(int row, int col, int ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/gnn_seq_engine_if.sv
// Result stream from the GNN engine: one beat per node, valid/ready handshake.
interface gnn_seq_engine_if #(
  parameter int NODE_W = 2,
  parameter int DATA_W = 46
);
  logic              out_valid;
  logic              out_ready;
  logic [NODE_W-1:0] out_node;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, out_node, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_node, out_data, out_last, output out_ready);
endinterface

// File: rtl/gnn_dot.sv
// Combinational signed dot product; result wraps to OW bits, callers size OW so
// every true result fits.
module gnn_dot #(
  parameter int LEN = 4,
  parameter int AW  = 8,
  parameter int BW  = 8,
  parameter int OW  = 16
) (
  input  logic signed [AW-1:0] a [LEN],
  input  logic signed [BW-1:0] b [LEN],
  output logic signed [OW-1:0] y
);

  always_comb begin
    y = '0;
    for (int t = 0; t < LEN; t++) begin
      y = y + OW'(a[t]) * OW'(b[t]);
    end
  end

endmodule

// File: rtl/gnn_seq_engine.sv
// Two-layer GNN on one shared dot unit, one element per cycle; first beat N*F_IN+2*N*F_HID+N*F_OUT cycles after start.
// Result beats held stable while out_ready is low; start is ignored until the engine is idle.
module gnn_seq_engine
  import gnn_pkg::*;
#(
  parameter int N_NODES = 4,
  parameter int F_IN    = 4,
  parameter int F_HID   = 4,
  parameter int F_OUT   = 2,
  parameter int DW      = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_NODES*F_IN*DW-1:0]      x_in,
  input  logic [N_NODES*N_NODES-1:0]      adj,
  input  logic [F_IN*F_HID*DW-1:0]        w1,
  input  logic [F_HID*F_OUT*DW-1:0]       w2,
  output logic                            busy,
  output logic                            done,
  gnn_seq_engine_if.master                out_if
);

  localparam int A1W  = a1w(N_NODES, DW);
  localparam int HW   = hw(N_NODES, DW, F_IN);
  localparam int A2W  = a2w(N_NODES, DW, F_IN);
  localparam int OW   = ow(N_NODES, DW, F_IN, F_HID);
  localparam int NW   = $clog2(N_NODES);
  localparam int FW   = $clog2(max3(F_IN, F_HID, F_OUT) + 1);
  localparam int LEN  = max3(N_NODES, F_IN, F_HID);
  localparam int AW   = A2W;
  localparam int BW   = HW;

  state_t         state_q, state_d;
  logic [NW-1:0]  node_q, node_d;
  logic [FW-1:0]  feat_q, feat_d;
  logic           done_q, done_d;
  logic           capture, wr_en;
  int             nfeat;
  state_t         phase_next;
  int             ni, fi;

  logic signed [DW-1:0]  x_r  [N_NODES][F_IN];
  logic                  adj_r[N_NODES][N_NODES];
  logic signed [DW-1:0]  w1_r [F_IN][F_HID];
  logic signed [DW-1:0]  w2_r [F_HID][F_OUT];
  logic signed [A1W-1:0] xa_r [N_NODES][F_IN];
  logic signed [HW-1:0]  h_r  [N_NODES][F_HID];
  logic signed [A2W-1:0] ha_r [N_NODES][F_HID];
  logic signed [OW-1:0]  y_r  [N_NODES][F_OUT];

  logic signed [AW-1:0]  dot_a [LEN];
  logic signed [BW-1:0]  dot_b [LEN];
  logic signed [OW-1:0]  dot_y;

  assign ni   = int'(node_q);
  assign fi   = int'(feat_q);
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      node_q  <= '0;
      feat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      feat_q  <= feat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    feat_d     = feat_q;
    done_d     = 1'b0;
    capture    = 1'b0;
    wr_en      = 1'b0;
    nfeat      = F_IN;
    phase_next = S_IDLE;
    case (state_q)
      S_AGG1:  begin nfeat = F_IN;  phase_next = S_MUL1; end
      S_MUL1:  begin nfeat = F_HID; phase_next = S_AGG2; end
      S_AGG2:  begin nfeat = F_HID; phase_next = S_MUL2; end
      S_MUL2:  begin nfeat = F_OUT; phase_next = S_OUT;  end
      default: ;
    endcase
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = S_AGG1;
          node_d  = '0;
          feat_d  = '0;
        end
      end
      S_OUT: begin
        if (out_if.out_ready) begin
          if (node_q == NW'(N_NODES - 1)) begin
            state_d = S_IDLE;
            node_d  = '0;
            done_d  = 1'b1;
          end else begin
            node_d = node_q + 1'b1;
          end
        end
      end
      default: begin
        wr_en = 1'b1;
        if (feat_q == FW'(nfeat - 1)) begin
          feat_d = '0;
          if (node_q == NW'(N_NODES - 1)) begin
            node_d  = '0;
            state_d = phase_next;
          end else begin
            node_d = node_q + 1'b1;
          end
        end else begin
          feat_d = feat_q + 1'b1;
        end
      end
    endcase
  end

  // Adjacency terms enter the dot unit as 0/1 multipliers with the self edge forced on.
  always_comb begin
    for (int t = 0; t < LEN; t++) begin
      dot_a[t] = '0;
      dot_b[t] = '0;
    end
    case (state_q)
      S_AGG1: for (int t = 0; t < N_NODES; t++) begin
        dot_a[t] = ((t == ni) || adj_r[ni][t]) ? AW'(1) : '0;
        dot_b[t] = BW'(x_r[t][fi]);
      end
      S_MUL1: for (int t = 0; t < F_IN; t++) begin
        dot_a[t] = AW'(xa_r[ni][t]);
        dot_b[t] = BW'(w1_r[t][fi]);
      end
      S_AGG2: for (int t = 0; t < N_NODES; t++) begin
        dot_a[t] = ((t == ni) || adj_r[ni][t]) ? AW'(1) : '0;
        dot_b[t] = BW'(h_r[t][fi]);
      end
      S_MUL2: for (int t = 0; t < F_HID; t++) begin
        dot_a[t] = ha_r[ni][t][A2W-1] ? '0 : AW'(ha_r[ni][t]);
        dot_b[t] = BW'(w2_r[t][fi]);
      end
      default: ;
    endcase
  end

  gnn_dot #(.LEN(LEN), .AW(AW), .BW(BW), .OW(OW)) u_dot (
    .a (dot_a),
    .b (dot_b),
    .y (dot_y)
  );

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_NODES; i++) begin
        for (int k = 0; k < F_IN; k++)
          x_r[i][k] <= x_in[flat_idx(i, k, F_IN)*DW +: DW];
        for (int j = 0; j < N_NODES; j++)
          adj_r[i][j] <= adj[flat_idx(i, j, N_NODES)];
      end
      for (int k = 0; k < F_IN; k++)
        for (int c = 0; c < F_HID; c++)
          w1_r[k][c] <= w1[flat_idx(k, c, F_HID)*DW +: DW];
      for (int c = 0; c < F_HID; c++)
        for (int o = 0; o < F_OUT; o++)
          w2_r[c][o] <= w2[flat_idx(c, o, F_OUT)*DW +: DW];
    end
    if (wr_en) begin
      case (state_q)
        S_AGG1:  xa_r[ni][fi] <= A1W'(dot_y);
        S_MUL1:  h_r[ni][fi]  <= HW'(dot_y);
        S_AGG2:  ha_r[ni][fi] <= A2W'(dot_y);
        S_MUL2:  y_r[ni][fi]  <= dot_y;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_if.out_valid = (state_q == S_OUT);
    out_if.out_last  = (state_q == S_OUT) && (node_q == NW'(N_NODES - 1));
    out_if.out_node  = (state_q == S_OUT) ? node_q : '0;
    out_if.out_data  = '0;
    if (state_q == S_OUT) begin
      for (int o = 0; o < F_OUT; o++)
        out_if.out_data[o*OW +: OW] = y_r[ni][o];
    end
  end

endmodule

// File: tb/tb_gnn_seq_engine.sv
// Bench for gnn_seq_engine: directed and random jobs against a plain-arithmetic
// reference of the two-layer network plus a beat-level timing model.
module tb_gnn_seq_engine;
  import gnn_pkg::*;

  localparam int N  = 4;
  localparam int FI = 4;
  localparam int FH = 4;
  localparam int FO = 2;
  localparam int DW = 5;
  localparam int OW = ow(N, DW, FI, FH);
  localparam int NW = $clog2(N);
  localparam int AJ = N * N;
  localparam int L  = N*FI + 2*N*FH + N*FO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N*FI*DW-1:0] x_in = '0;
  logic [AJ-1:0]      adj = '0;
  logic [FI*FH*DW-1:0] w1 = '0;
  logic [FH*FO*DW-1:0] w2 = '0;
  logic busy, done;

  gnn_seq_engine_if #(.NODE_W(NW), .DATA_W(FO*OW)) ifc ();

  gnn_seq_engine #(.N_NODES(N), .F_IN(FI), .F_HID(FH), .F_OUT(FO), .DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x_in   (x_in),
    .adj    (adj),
    .w1     (w1),
    .w2     (w2),
    .busy   (busy),
    .done   (done),
    .out_if (ifc.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  // Reference results and timing model state
  longint y_exp [N][FO];
  bit     m_busy = 1'b0;
  bit     m_done = 1'b0;
  int     m_cnt  = 0;
  int     m_beat = 0;
  bit     ev;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint xval(int j, int k);
    return longint'($signed(x_in[(j*FI + k)*DW +: DW]));
  endfunction

  function automatic longint w1val(int k, int c);
    return longint'($signed(w1[(k*FH + c)*DW +: DW]));
  endfunction

  function automatic longint w2val(int c, int o);
    return longint'($signed(w2[(c*FO + o)*DW +: DW]));
  endfunction

  function automatic longint ah(int i, int j);
    return (i == j || adj[i*N + j]) ? 64'sd1 : 64'sd0;
  endfunction

  task automatic compute_model();
    longint xa [N][FI];
    longint h  [N][FH];
    longint ha [N][FH];
    for (int i = 0; i < N; i++)
      for (int k = 0; k < FI; k++) begin
        xa[i][k] = 0;
        for (int j = 0; j < N; j++) xa[i][k] += ah(i, j) * xval(j, k);
      end
    for (int i = 0; i < N; i++)
      for (int c = 0; c < FH; c++) begin
        h[i][c] = 0;
        for (int k = 0; k < FI; k++) h[i][c] += xa[i][k] * w1val(k, c);
      end
    for (int i = 0; i < N; i++)
      for (int c = 0; c < FH; c++) begin
        ha[i][c] = 0;
        for (int j = 0; j < N; j++) ha[i][c] += ah(i, j) * h[j][c];
      end
    for (int i = 0; i < N; i++)
      for (int o = 0; o < FO; o++) begin
        y_exp[i][o] = 0;
        for (int c = 0; c < FH; c++)
          y_exp[i][o] += ((ha[i][c] > 0) ? ha[i][c] : 64'sd0) * w2val(c, o);
      end
  endtask

  // Job timing: L compute cycles after the accepting edge, then one beat per handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_beat <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          m_beat <= 0;
        end
      end else if (m_cnt < L) begin
        m_cnt <= m_cnt + 1;
      end else if (ifc.out_ready) begin
        if (m_beat == N - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_beat <= 0;
        end else begin
          m_beat <= m_beat + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && checking) begin
      ev = m_busy && (m_cnt == L);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("out_valid", ifc.out_valid, ev);
      if (ev) begin
        chk("out_node", ifc.out_node, m_beat);
        chk("out_last", ifc.out_last, (m_beat == N - 1));
        for (int o = 0; o < FO; o++)
          chk("out_data", $signed(ifc.out_data[o*OW +: OW]), y_exp[m_beat][o]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input int xv, input logic [AJ-1:0] a, input int w1v, input int w2v);
    for (int i = 0; i < N*FI; i++) x_in[i*DW +: DW] = DW'(xv);
    for (int i = 0; i < FI*FH; i++) w1[i*DW +: DW] = DW'(w1v);
    for (int i = 0; i < FH*FO; i++) w2[i*DW +: DW] = DW'(w2v);
    adj = a;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N*FI; i++) x_in[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < FI*FH; i++) w1[i*DW +: DW] = DW'($urandom);
    for (int i = 0; i < FH*FO; i++) w2[i*DW +: DW] = DW'($urandom);
    adj = AJ'($urandom);
  endtask

  // Inputs are scrambled right after the start edge to prove they were captured.
  task automatic run_job(input bit rand_rdy, input bit poke_start,
                         output int fv, output int dc, output longint e0);
    bit seen;
    compute_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    randomize_inputs();
    fv = -1;
    dc = -1;
    e0 = 0;
    seen = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      ifc.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start) start = (c == 10 || c == 11 || c == L + 1);
      tick();
      if (!seen && ifc.out_valid) begin
        seen = 1'b1;
        fv = c;
        e0 = longint'($signed(ifc.out_data[OW-1:0]));
      end
      if (done) begin
        dc = c;
        break;
      end
    end
    start = 1'b0;
    if (dc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL job_timeout: done never seen within 3000 cycles");
    end
  endtask

  logic [AJ-1:0] ring;
  int fv, dc;
  longint e0;

  initial begin
    ifc.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", ifc.out_valid, 0);
    chk("reset_out_node", ifc.out_node, 0);
    chk("reset_out_data", ifc.out_data, 0);
    chk("reset_out_last", ifc.out_last, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;
    tick();

    set_all(1, '0, 1, 1);
    run_job(1'b0, 1'b0, fv, dc, e0);
    chk("t1_first_valid_latency", fv, 56);
    chk("t1_done_after_first_valid", dc - fv, 4);
    chk("t1_elem0", e0, 16);

    set_all(1, '1, 1, 1);
    run_job(1'b0, 1'b0, fv, dc, e0);
    chk("t2_elem0", e0, 256);

    set_all(1, '0, -1, 1);
    run_job(1'b0, 1'b0, fv, dc, e0);
    chk("t3_relu_elem0", e0, 0);

    set_all(-16, '1, -16, -16);
    run_job(1'b0, 1'b0, fv, dc, e0);
    chk("t4_extreme_elem0", e0, -1048576);

    ring = '0;
    for (int i = 0; i < N; i++) ring[i*N + (i + N - 1) % N] = 1'b1;
    set_all(0, ring, 0, 1);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < FI; k++) x_in[(i*FI + k)*DW +: DW] = DW'(i);
    for (int k = 0; k < FI; k++) w1[(k*FH + k)*DW +: DW] = DW'(1);
    run_job(1'b1, 1'b0, fv, dc, e0);
    chk("t5_ring_node0", y_exp[0][0], 32);
    chk("t5_ring_node1", y_exp[1][1], 16);
    chk("t5_ring_node3", y_exp[3][0], 32);
    chk("t5_ring_elem0", e0, 32);

    for (int r = 0; r < 4; r++) begin
      randomize_inputs();
      run_job(1'b1, (r == 1), fv, dc, e0);
    end

    randomize_inputs();
    compute_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", ifc.out_valid, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    randomize_inputs();
    run_job(1'b1, 1'b1, fv, dc, e0);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
